// File: rtl/sys_ctrl_cmd_if.sv
// sys_ctrl_cmd_if -- bundle of the command-controller bus signals.
//   UART_RX_*       : received frames from the UART receiver
//   RF_*            : register-file write/read port
//   ALU_*           : ALU request / result
//   CLKG_EN/CLKDIV_EN : clock-gate and clock-divider enables
//   TX_*            : response frames towards the UART transmitter
//   CMD_ERR         : one-cycle error pulse
// Modports: master = controller side, slave = environment side.
interface sys_ctrl_cmd_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4,
  parameter int ALU_FUN_W  = 4
);
  logic [DATA_WIDTH-1:0]   UART_RX_DATA;
  logic                    UART_RX_VLD;
  logic                    RF_WrEn;
  logic                    RF_RdEn;
  logic [RF_ADDR-1:0]      RF_Address;
  logic [DATA_WIDTH-1:0]   RF_WrData;
  logic [DATA_WIDTH-1:0]   RF_RdData;
  logic                    RF_RdData_VLD;
  logic                    ALU_EN;
  logic [ALU_FUN_W-1:0]    ALU_FUN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic                    CLKG_EN;
  logic                    CLKDIV_EN;
  logic [DATA_WIDTH-1:0]   TX_DATA;
  logic                    TX_VLD;
  logic                    TX_RDY;
  logic                    CMD_ERR;

  modport master (
    input  UART_RX_DATA, UART_RX_VLD, RF_RdData, RF_RdData_VLD,
           ALU_OUT, ALU_OUT_VLD, TX_RDY,
    output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
           CLKG_EN, CLKDIV_EN, TX_DATA, TX_VLD, CMD_ERR
  );

  modport slave (
    output UART_RX_DATA, UART_RX_VLD, RF_RdData, RF_RdData_VLD,
           ALU_OUT, ALU_OUT_VLD, TX_RDY,
    input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
           CLKG_EN, CLKDIV_EN, TX_DATA, TX_VLD, CMD_ERR
  );
endinterface

// File: rtl/sys_ctrl_cmd.sv
// sys_ctrl_cmd -- UART command decoder / system controller.
// Frames arriving on the UART are decoded as commands:
//   0xAA addr data      : RF write
//   0xBB addr           : RF read, result returned as one TX frame
//   0xCC a b fun        : write operands to RF[0]/RF[1], run ALU, two TX frames
//   0xDD fun            : run ALU on current operands, two TX frames (LSB first)
// Ports: CLK, RST (async active low), bus (sys_ctrl_cmd_if.master).
// All outputs are registered.
// Build option: SYS_CTRL_TIMEOUT_EN adds an inter-frame timeout of TIMEOUT
// cycles in the frame-collecting states; without it those states wait forever.
module sys_ctrl_cmd #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4,
  parameter int ALU_FUN_W  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic CLK,
  input  logic RST,
  sys_ctrl_cmd_if.master bus
);
  localparam logic [DATA_WIDTH-1:0] OPC_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OPC_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OPC_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                  state, state_nxt;
  logic [RF_ADDR-1:0]      wr_addr, wr_addr_nxt;
  logic [DATA_WIDTH-1:0]   rsp_hi, rsp_hi_nxt;   // MSB frame of an ALU result
  logic                    is_alu, is_alu_nxt;   // current command uses the ALU
  logic                    rf_wr_en, rf_wr_en_nxt;
  logic                    rf_rd_en, rf_rd_en_nxt;
  logic [RF_ADDR-1:0]      rf_address, rf_address_nxt;
  logic [DATA_WIDTH-1:0]   rf_wr_data, rf_wr_data_nxt;
  logic                    alu_en, alu_en_nxt;
  logic [ALU_FUN_W-1:0]    alu_fun, alu_fun_nxt;
  logic                    clkg_en, clkg_en_nxt;
  logic                    clkdiv_en;
  logic [DATA_WIDTH-1:0]   tx_data, tx_data_nxt;
  logic                    tx_vld, tx_vld_nxt;
  logic                    cmd_err, cmd_err_nxt;

  logic rx;
  assign rx = bus.UART_RX_VLD;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo, tmo_nxt;
`else
  // TIMEOUT is only consumed by the timeout build.
  if (TIMEOUT < 0) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      wr_addr    <= '0;
      rsp_hi     <= '0;
      is_alu     <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_address <= '0;
      rf_wr_data <= '0;
      alu_en     <= 1'b0;
      alu_fun    <= '0;
      clkg_en    <= 1'b0;
      clkdiv_en  <= 1'b1;
      tx_data    <= '0;
      tx_vld     <= 1'b0;
      cmd_err    <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
      tmo        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      wr_addr    <= wr_addr_nxt;
      rsp_hi     <= rsp_hi_nxt;
      is_alu     <= is_alu_nxt;
      rf_wr_en   <= rf_wr_en_nxt;
      rf_rd_en   <= rf_rd_en_nxt;
      rf_address <= rf_address_nxt;
      rf_wr_data <= rf_wr_data_nxt;
      alu_en     <= alu_en_nxt;
      alu_fun    <= alu_fun_nxt;
      clkg_en    <= clkg_en_nxt;
      clkdiv_en  <= 1'b1;
      tx_data    <= tx_data_nxt;
      tx_vld     <= tx_vld_nxt;
      cmd_err    <= cmd_err_nxt;
`ifdef SYS_CTRL_TIMEOUT_EN
      tmo        <= tmo_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    wr_addr_nxt    = wr_addr;
    rsp_hi_nxt     = rsp_hi;
    is_alu_nxt     = is_alu;
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = rf_rd_en;
    rf_address_nxt = rf_address;
    rf_wr_data_nxt = rf_wr_data;
    alu_en_nxt     = alu_en;
    alu_fun_nxt    = alu_fun;
    tx_data_nxt    = tx_data;
    tx_vld_nxt     = tx_vld;
    cmd_err_nxt    = 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
    tmo_nxt        = '0;
`endif

    unique case (state)
      IDLE: if (rx) begin
        if (bus.UART_RX_DATA == OPC_WR) begin
          state_nxt = WR_ADDR; is_alu_nxt = 1'b0;
        end else if (bus.UART_RX_DATA == OPC_RD) begin
          state_nxt = RD_ADDR; is_alu_nxt = 1'b0;
        end else if (bus.UART_RX_DATA == OPC_ALU) begin
          state_nxt = OP_A;    is_alu_nxt = 1'b1;
        end else if (bus.UART_RX_DATA == OPC_FUN) begin
          state_nxt = FUN;     is_alu_nxt = 1'b1;
        end else begin
          cmd_err_nxt = 1'b1;
        end
      end
      WR_ADDR: if (rx) begin
        wr_addr_nxt = bus.UART_RX_DATA[RF_ADDR-1:0];
        state_nxt   = WR_DATA;
      end
      WR_DATA: if (rx) begin
        rf_wr_en_nxt   = 1'b1;
        rf_address_nxt = wr_addr;
        rf_wr_data_nxt = bus.UART_RX_DATA;
        state_nxt      = IDLE;
      end
      RD_ADDR: if (rx) begin
        rf_rd_en_nxt   = 1'b1;
        rf_address_nxt = bus.UART_RX_DATA[RF_ADDR-1:0];
        state_nxt      = RD_WAIT;
      end
      RD_WAIT: if (bus.RF_RdData_VLD) begin
        rf_rd_en_nxt = 1'b0;
        tx_data_nxt  = bus.RF_RdData;
        tx_vld_nxt   = 1'b1;
        state_nxt    = TX_LO;
      end
      OP_A: if (rx) begin
        rf_wr_en_nxt   = 1'b1;
        rf_address_nxt = '0;
        rf_wr_data_nxt = bus.UART_RX_DATA;
        state_nxt      = OP_B;
      end
      OP_B: if (rx) begin
        rf_wr_en_nxt   = 1'b1;
        rf_address_nxt = RF_ADDR'(1);
        rf_wr_data_nxt = bus.UART_RX_DATA;
        state_nxt      = FUN;
      end
      FUN: if (rx) begin
        alu_fun_nxt = bus.UART_RX_DATA[ALU_FUN_W-1:0];
        alu_en_nxt  = 1'b1;
        state_nxt   = ALU_WAIT;
      end
      ALU_WAIT: if (bus.ALU_OUT_VLD) begin
        alu_en_nxt  = 1'b0;
        tx_data_nxt = bus.ALU_OUT[DATA_WIDTH-1:0];
        rsp_hi_nxt  = bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
        tx_vld_nxt  = 1'b1;
        state_nxt   = TX_LO;
      end
      TX_LO: if (bus.TX_RDY) begin
        if (is_alu) begin
          tx_data_nxt = rsp_hi;
          state_nxt   = TX_HI;
        end else begin
          tx_vld_nxt  = 1'b0;
          state_nxt   = IDLE;
        end
      end
      TX_HI: if (bus.TX_RDY) begin
        tx_vld_nxt = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A frame arriving while busy is dropped and flagged as an overrun.
    if (rx && (state inside {RD_WAIT, ALU_WAIT, TX_LO, TX_HI}))
      cmd_err_nxt = 1'b1;

`ifdef SYS_CTRL_TIMEOUT_EN
    // Counter restarts on every frame; all entries into these states happen
    // on a frame or from a non-counting state, so entry also clears it.
    if (!rx && (state inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN})) begin
      if (tmo == TW'(TIMEOUT - 1)) begin
        cmd_err_nxt = 1'b1;
        state_nxt   = IDLE;
      end else begin
        tmo_nxt = tmo + 1'b1;
      end
    end
`endif

    // Gate enable tracks the state being entered so it lines up with it.
    unique case (state_nxt)
      OP_A, OP_B, FUN, ALU_WAIT: clkg_en_nxt = 1'b1;
      TX_LO, TX_HI:              clkg_en_nxt = is_alu_nxt;
      default:                   clkg_en_nxt = 1'b0;
    endcase
  end

  assign bus.RF_WrEn    = rf_wr_en;
  assign bus.RF_RdEn    = rf_rd_en;
  assign bus.RF_Address = rf_address;
  assign bus.RF_WrData  = rf_wr_data;
  assign bus.ALU_EN     = alu_en;
  assign bus.ALU_FUN    = alu_fun;
  assign bus.CLKG_EN    = clkg_en;
  assign bus.CLKDIV_EN  = clkdiv_en;
  assign bus.TX_DATA    = tx_data;
  assign bus.TX_VLD     = tx_vld;
  assign bus.CMD_ERR    = cmd_err;
endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// tb_sys_ctrl_cmd -- randomized transaction-level bench for sys_ctrl_cmd.
// Inputs are driven just after the rising edge (responders at the falling
// edge); outputs are observed at the falling edge.
module tb_sys_ctrl_cmd;
  localparam int DW = 8, RA = 4, FW = 4;
  localparam logic [63:0] NONE = '1;  // never matches a zero-extended observation

  logic CLK = 1'b0, RST = 1'b0;
  always #5 CLK = ~CLK;

  sys_ctrl_cmd_if #(.DATA_WIDTH(DW), .RF_ADDR(RA), .ALU_FUN_W(FW)) bus ();
  sys_ctrl_cmd #(.DATA_WIDTH(DW), .RF_ADDR(RA), .ALU_FUN_W(FW), .TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int n_vec = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Transaction model
  logic [63:0]    exp_wr[$];
  logic [63:0]    exp_tx[$];
  logic [FW-1:0]  exp_fun;
  logic [RA-1:0]  exp_rd_addr;
  int  exp_err = 0, err_seen = 0, tx_cnt = 0;
  bit  cur_alu = 1'b0;
  // Directed-test knobs
  int  rd_force = -1, alu_force = -1, rdy_block = 0;
  bit  rd_dforce = 0, res_force_en = 0, rdy_always = 0;
  logic [DW-1:0]   rd_dval;
  logic [2*DW-1:0] res_force;

  function automatic logic [63:0] outs();
    return 64'({bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData, bus.ALU_EN,
                bus.ALU_FUN, bus.CLKG_EN, bus.TX_DATA, bus.TX_VLD, bus.CMD_ERR});
  endfunction

  // Output monitor
  initial begin
    logic prev_vld, prev_rdy;
    logic [DW-1:0] prev_data;
    logic [63:0] e;
    prev_vld = 0; prev_rdy = 0; prev_data = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (bus.RF_WrEn) begin
          e = (exp_wr.size() > 0) ? exp_wr.pop_front() : NONE;
          chk("rf_write", 64'({bus.RF_Address, bus.RF_WrData}), e);
        end
        if (bus.CMD_ERR) err_seen++;
        if (bus.TX_VLD) begin
          if (prev_vld && !prev_rdy) chk("tx_hold", 64'(bus.TX_DATA), 64'(prev_data));
          if (bus.TX_RDY) begin
            e = (exp_tx.size() > 0) ? exp_tx.pop_front() : NONE;
            chk("tx_data", 64'(bus.TX_DATA), e);
            chk("tx_clkg", 64'(bus.CLKG_EN), 64'(cur_alu));
            tx_cnt++;
          end
        end else if (prev_vld && !prev_rdy) begin
          chk("tx_drop", 64'(bus.TX_VLD), 64'd1);
        end
        prev_vld = bus.TX_VLD; prev_rdy = bus.TX_RDY; prev_data = bus.TX_DATA;
      end else begin
        prev_vld = 0; prev_rdy = 0;
      end
    end
  end

  // Register-file read responder
  initial begin
    int rd_cnt;
    logic [DW-1:0] d;
    rd_cnt = -1;
    bus.RF_RdData_VLD = 0; bus.RF_RdData = '0;
    forever begin
      @(negedge CLK);
      if (bus.RF_RdData_VLD) bus.RF_RdData_VLD = 0;
      else if (RST && bus.RF_RdEn) begin
        if (rd_cnt < 0) rd_cnt = (rd_force >= 0) ? rd_force : int'($urandom_range(0, 3));
        if (rd_cnt == 0) begin
          chk("rd_addr", 64'(bus.RF_Address), 64'(exp_rd_addr));
          chk("rd_clkg", 64'(bus.CLKG_EN), 64'd0);
          d = rd_dforce ? rd_dval : DW'($urandom);
          bus.RF_RdData = d; bus.RF_RdData_VLD = 1;
          exp_tx.push_back(64'(d));
          rd_cnt = -1;
        end else rd_cnt--;
      end
    end
  end

  // ALU responder
  initial begin
    int al_cnt;
    logic [2*DW-1:0] r;
    al_cnt = -1;
    bus.ALU_OUT_VLD = 0; bus.ALU_OUT = '0;
    forever begin
      @(negedge CLK);
      if (bus.ALU_OUT_VLD) bus.ALU_OUT_VLD = 0;
      else if (RST && bus.ALU_EN) begin
        if (al_cnt < 0) al_cnt = (alu_force >= 0) ? alu_force : int'($urandom_range(0, 3));
        if (al_cnt == 0) begin
          chk("alu_fun", 64'(bus.ALU_FUN), 64'(exp_fun));
          chk("alu_clkg", 64'(bus.CLKG_EN), 64'd1);
          r = res_force_en ? res_force : (2*DW)'($urandom);
          bus.ALU_OUT = r; bus.ALU_OUT_VLD = 1;
          exp_tx.push_back(64'(r[DW-1:0]));
          exp_tx.push_back(64'(r[2*DW-1:DW]));
          al_cnt = -1;
        end else al_cnt--;
      end
    end
  end

  // TX ready driver
  initial begin
    bus.TX_RDY = 0;
    forever begin
      @(posedge CLK); #1;
      if (rdy_block > 0 && bus.TX_VLD) begin
        bus.TX_RDY = 0; rdy_block--;
      end else bus.TX_RDY = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [DW-1:0] d, input int gap);
    @(posedge CLK); #1;
    bus.UART_RX_DATA = d; bus.UART_RX_VLD = 1;
    @(posedge CLK); #1;
    bus.UART_RX_VLD = 0; bus.UART_RX_DATA = DW'($urandom);
    repeat (gap) @(posedge CLK);
  endtask

  // Final frame followed back-to-back by a junk frame while the DUT is busy.
  task automatic send_ovr(input logic [DW-1:0] d);
    @(posedge CLK); #1;
    bus.UART_RX_DATA = d; bus.UART_RX_VLD = 1;
    @(posedge CLK); #1;
    bus.UART_RX_DATA = DW'($urandom);
    @(posedge CLK); #1;
    bus.UART_RX_VLD = 0;
    exp_err++;
  endtask

  task automatic wait_tx(input int target);
    for (int i = 0; i < 300 && tx_cnt < target; i++) @(posedge CLK);
    chk("tx_count", 64'(tx_cnt), 64'(target));
  endtask

  task automatic end_cmd();
    repeat (2) @(posedge CLK); #1;
    chk("err_cnt", 64'(err_seen), 64'(exp_err));
    chk("wr_left", 64'(exp_wr.size()), 64'd0);
    chk("tx_left", 64'(exp_tx.size()), 64'd0);
    chk("idle_outs", 64'({bus.RF_RdEn, bus.ALU_EN, bus.TX_VLD, bus.CLKG_EN}), 64'd0);
  endtask

  task automatic do_write(input logic [DW-1:0] a, input logic [DW-1:0] d);
    exp_wr.push_back(64'({a[RA-1:0], d}));
    send(8'hAA, $urandom_range(0, 2));
    send(a, $urandom_range(0, 2));
    send(d, 0);
    end_cmd();
  endtask

  task automatic do_read(input logic [DW-1:0] a, input bit ovr);
    int tgt;
    exp_rd_addr = a[RA-1:0];
    tgt = tx_cnt + 1;
    send(8'hBB, $urandom_range(0, 2));
    if (ovr) send_ovr(a); else send(a, 0);
    wait_tx(tgt);
    end_cmd();
  endtask

  task automatic do_alu(input bit full, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] f, input bit ovr);
    int tgt;
    cur_alu = 1;
    if (full) begin
      exp_wr.push_back(64'({RA'(0), a}));
      exp_wr.push_back(64'({RA'(1), b}));
      send(8'hCC, $urandom_range(0, 2));
      send(a, $urandom_range(0, 2));
      send(b, $urandom_range(0, 2));
    end else send(8'hDD, $urandom_range(0, 2));
    exp_fun = f[FW-1:0];
    tgt = tx_cnt + 2;
    if (ovr) send_ovr(f); else send(f, 0);
    wait_tx(tgt);
    cur_alu = 0;
    end_cmd();
  endtask

  task automatic do_bad(input logic [DW-1:0] op);
    logic [63:0] snap;
    @(negedge CLK);
    snap = outs();
    exp_err++;
    send(op, 0);
    chk("bad_pulse", 64'(bus.CMD_ERR), 64'd1);
    repeat (2) @(posedge CLK); #1;
    chk("bad_quiet", outs(), snap);
    end_cmd();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] op;
    bus.UART_RX_VLD = 0; bus.UART_RX_DATA = '0;
    repeat (3) @(posedge CLK); #1;
    chk("rst_outs", outs(), 64'd0);
    chk("rst_clkdiv", 64'(bus.CLKDIV_EN), 64'd1);
    RST = 1;
    repeat (2) @(posedge CLK);

    // Directed scenarios
    do_write(8'h05, 8'h3C);
    rd_force = 3; rd_dforce = 1; rd_dval = 8'h77; rdy_block = 2; rdy_always = 1;
    do_read(8'h02, 0);
    rd_force = -1; rd_dforce = 0; rdy_always = 0;
    res_force_en = 1; res_force = 16'h0030;
    do_alu(1, 8'h10, 8'h20, 8'h01, 0);
    res_force_en = 0;
    do_bad(8'h55);
    alu_force = 0; do_alu(0, 8'h00, 8'h00, 8'h07, 1); alu_force = -1;
    rd_force = 0;  do_read(8'h0B, 0); do_read(8'hF3, 1); rd_force = -1;

    // Long silence inside a command
`ifdef SYS_CTRL_TIMEOUT_EN
    send(8'hAA, 0);
    repeat (260) @(posedge CLK);
    exp_err++;
    end_cmd();
`else
    exp_wr.push_back(64'({4'h5, 8'h3C}));
    send(8'hAA, 300);
    send(8'h05, 0);
    send(8'h3C, 0);
    end_cmd();
`endif

    // Reset while collecting the write data frame
    send(8'hAA, 0);
    send(8'h05, 0);
    @(posedge CLK); #1;
    RST = 0; #1;
    chk("midrst_outs", outs(), 64'd0);
    chk("midrst_clkdiv", 64'(bus.CLKDIV_EN), 64'd1);
    repeat (2) @(posedge CLK); #1;
    RST = 1;
    do_bad(8'h3C);  // the abandoned data frame is now an unknown opcode

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: do_write(DW'($urandom), DW'($urandom));
        1: do_read(DW'($urandom), $urandom_range(0, 3) == 0);
        2: do_alu($urandom_range(0, 1) == 1, DW'($urandom), DW'($urandom), DW'($urandom),
                  $urandom_range(0, 3) == 0);
        default: begin
          op = DW'($urandom);
          while (op inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) op = DW'($urandom);
          do_bad(op);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
